run_key_ctrl: RTL and testbench
===============================

RUN_KEY_CTRL -- requirements
Module: run_key_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, stable-level cycles required to accept a key edge (legal range >= 2).
REQ-002 SHALL have parameter LONG_CYCLES, default 200000000, held cycles after press acceptance that constitute a long press (legal range > DEB_CYCLES).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port key_in, input, 1, raw asynchronous push-button, high = pressed.
REQ-006 SHALL have port run, output, 1, registered count-enable level driving the seconds counter enable input.
REQ-007 SHALL have port press_pulse, output, 1, one-cycle strobe per accepted press.
REQ-008 SHALL have port clr_pulse, output, 1, one-cycle strobe requesting a counter-chain clear.
REQ-009 SHALL have port key_state, output, 2, current FSM state code.

Function
REQ-010 SHALL pass key_in through a 2-flop synchroniser; only the second flop output (key_s) feeds the FSM.
REQ-011 SHALL implement FSM states IDLE=0, PRESS_DEB=1, HELD=2, REL_DEB=3, reflected on key_state.
REQ-012 IDLE: key_s=1 -> PRESS_DEB, debounce counter cleared to 0.
REQ-013 PRESS_DEB: key_s=0 -> IDLE; counter reaching DEB_CYCLES-1 with key_s=1 -> HELD; otherwise increment.
REQ-014 On PRESS_DEB->HELD: press_pulse=1 for exactly that one cycle, run toggles, hold counter cleared.
REQ-015 Latency key_in rise to press_pulse SHALL be DEB_CYCLES+3 cycles for a clean input.
REQ-016 HELD: key_s=0 -> REL_DEB, debounce counter cleared; hold counter increments and saturates at LONG_CYCLES-1.
REQ-017 REL_DEB: key_s=1 -> HELD with hold counter preserved; counter reaching DEB_CYCLES-1 with key_s=0 -> IDLE.
REQ-018 Bounces shorter than DEB_CYCLES in PRESS_DEB or REL_DEB SHALL produce no press_pulse, clr_pulse, or run change.
REQ-019 Counters SHALL be wide enough for LONG_CYCLES-1 without overflow; no wrap-around.
REQ-020 At most one press_pulse and one clr_pulse per physical press, regardless of hold duration.
REQ-021 press_pulse and clr_pulse SHALL never both be high in the same cycle.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force state IDLE, both counters 0, synchroniser flops 0, run=0, press_pulse=0, clr_pulse=0, key_state=0.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL abandon the operation; a new full debounce is required after release of reset.
REQ-024 No output SHALL change in response to rst_n between clock edges.

Configuration
REQ-025 Macro KEY_LONG_CLEAR_EN defined: in HELD, when the hold counter first reaches LONG_CYCLES-1, clr_pulse=1 for one cycle and run forced to 0 in the same edge.
REQ-026 Macro KEY_LONG_CLEAR_EN undefined: clr_pulse tied 0, hold counter logic removed, a long press behaves as a short press.

Verification (DEB_CYCLES=4, LONG_CYCLES=16)
REQ-027 key_in=1 held, rst_n=0 for 3 cycles -> run=0, press_pulse=0, clr_pulse=0, key_state=0 throughout.
REQ-028 Clean press, key_in high 12 cycles -> single press_pulse 7 cycles after rise, run 0->1; second identical press -> run 1->0.
REQ-029 key_in high 2, low 1, high 2, low -> no press_pulse, run unchanged, key_state returns to 0.
REQ-030 Macro defined, key_in high 30 cycles -> press_pulse (run=1), then exactly one clr_pulse 16 cycles later with run=0.
REQ-031 Macro undefined, same 30-cycle hold -> clr_pulse stays 0, run remains 1.
REQ-032 rst_n pulsed low 1 cycle during PRESS_DEB -> key_state=0, no press_pulse; with key_in still high, press_pulse follows 7 cycles after rst_n returns high.

Source files
------------

// File: rtl/run_key_ctrl.sv
// Debounced run/stop push-button controller with toggle-on-press run level.
// Optional long-press counter clear enabled by defining KEY_LONG_CLEAR_EN.
module run_key_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       run,
    output logic       press_pulse,
    output logic       clr_pulse,
    output logic [1:0] key_state
);

    localparam int CW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    state_t        state;
    logic          sync1;
    logic          key_s;
    logic [CW-1:0] deb_cnt;

`ifdef KEY_LONG_CLEAR_EN
    localparam logic [CW-1:0] HOLD_MAX = CW'(LONG_CYCLES - 1);
    logic [CW-1:0] hold_cnt;
    logic          long_done;
`endif

    assign key_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            key_s       <= 1'b0;
            deb_cnt     <= '0;
            run         <= 1'b0;
            press_pulse <= 1'b0;
`ifdef KEY_LONG_CLEAR_EN
            clr_pulse   <= 1'b0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
`endif
        end else begin
            sync1       <= key_in;
            key_s       <= sync1;
            press_pulse <= 1'b0;
`ifdef KEY_LONG_CLEAR_EN
            clr_pulse   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (key_s) begin
                        state   <= PRESS_DEB;
                        deb_cnt <= '0;
                    end
                end
                PRESS_DEB: begin
                    if (!key_s) begin
                        state <= IDLE;
                    end else if (deb_cnt == DEB_MAX) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        run         <= ~run;
`ifdef KEY_LONG_CLEAR_EN
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
`endif
                    end else begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!key_s) begin
                        state   <= REL_DEB;
                        deb_cnt <= '0;
                    end
`ifdef KEY_LONG_CLEAR_EN
                    // Fires once on the first cycle seen at saturation
                    if (hold_cnt == HOLD_MAX) begin
                        if (!long_done) begin
                            clr_pulse <= 1'b1;
                            run       <= 1'b0;
                            long_done <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
`endif
                end
                REL_DEB: begin
                    if (key_s) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_MAX) begin
                        state <= IDLE;
                    end else begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef KEY_LONG_CLEAR_EN
    assign clr_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_run_key_ctrl.sv
// Scoreboard bench for run_key_ctrl with DEB_CYCLES=4, LONG_CYCLES=16.
// Expected pulse events are queued at stimulus time and matched on output.
module tb_run_key_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 16;
    localparam int LAT  = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_in;
    logic       run;
    logic       press_pulse;
    logic       clr_pulse;
    logic [1:0] key_state;

    typedef struct {
        bit kind;
        int cyc;
        bit run_v;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    bit  run_m = 1'b0;

    run_key_ctrl #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_in(key_in),
        .run(run),
        .press_pulse(press_pulse),
        .clr_pulse(clr_pulse),
        .key_state(key_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (press_pulse && clr_pulse) begin
            tests++;
            fails++;
            $display("FAIL both_pulses cyc=%0d press=1 clr=1 required not both", cyc);
        end
        if (press_pulse || clr_pulse) begin
            ev_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse cyc=%0d press=%0b clr=%0b required none",
                         cyc, press_pulse, clr_pulse);
            end else begin
                e = exp_q.pop_front();
                if (clr_pulse !== e.kind || cyc !== e.cyc || run !== e.run_v) begin
                    fails++;
                    $display("FAIL pulse_event got kind=%0b cyc=%0d run=%0b required kind=%0b cyc=%0d run=%0b",
                             clr_pulse, cyc, run, e.kind, e.cyc, e.run_v);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({run, press_pulse, clr_pulse, key_state} !== 5'b0) begin
                fails++;
                $display("FAIL reset_hold i=%0d run=%0b press=%0b clr=%0b st=%0d required all 0",
                         i, run, press_pulse, clr_pulse, key_state);
            end
        end
        step(1);
        rst_n  = 1'b1;
        key_in = 1'b0;
        step(4);
        tests++;
        if (key_state !== 2'd0 || run !== 1'b0) begin
            fails++;
            $display("FAIL reset_release st=%0d run=%0b required st=0 run=0", key_state, run);
        end
    endtask

    task automatic test_press(input string nm);
        key_in = 1'b1;
        run_m  = ~run_m;
        exp_q.push_back('{1'b0, cyc + LAT, run_m});
        step(LAT - 3);
        tests++;
        if (key_state !== 2'd1) begin
            fails++;
            $display("FAIL %s_deb_state st=%0d required 1", nm, key_state);
        end
        step(12 - (LAT - 3));
        tests++;
        if (key_state !== 2'd2) begin
            fails++;
            $display("FAIL %s_held_state st=%0d required 2", nm, key_state);
        end
        key_in = 1'b0;
        step(15);
        tests++;
        if (key_state !== 2'd0 || run !== run_m || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_end st=%0d run=%0b pending=%0d required st=0 run=%0b pending=0",
                     nm, key_state, run, exp_q.size(), run_m);
        end
    endtask

    task automatic test_bounce();
        key_in = 1'b1;
        step(2);
        key_in = 1'b0;
        step(1);
        key_in = 1'b1;
        step(2);
        key_in = 1'b0;
        step(12);
        tests++;
        if (key_state !== 2'd0 || run !== run_m || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bounce st=%0d run=%0b pending=%0d required st=0 run=%0b pending=0",
                     key_state, run, exp_q.size(), run_m);
        end
    endtask

    task automatic test_long_press();
        key_in = 1'b1;
        run_m  = ~run_m;
        exp_q.push_back('{1'b0, cyc + LAT, run_m});
`ifdef KEY_LONG_CLEAR_EN
        run_m = 1'b0;
        exp_q.push_back('{1'b1, cyc + LAT + LONG, 1'b0});
`endif
        step(30);
        key_in = 1'b0;
        step(15);
        tests++;
        if (key_state !== 2'd0 || run !== run_m || exp_q.size() != 0) begin
            fails++;
            $display("FAIL long_press st=%0d run=%0b pending=%0d required st=0 run=%0b pending=0",
                     key_state, run, exp_q.size(), run_m);
        end
    endtask

    task automatic test_reset_mid();
        key_in = 1'b1;
        step(4);
        tests++;
        if (key_state !== 2'd1) begin
            fails++;
            $display("FAIL mid_pre_state st=%0d required 1", key_state);
        end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        run_m = 1'b0;
        tests++;
        if (key_state !== 2'd0 || run !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset st=%0d run=%0b required st=0 run=0", key_state, run);
        end
        run_m = 1'b1;
        exp_q.push_back('{1'b0, cyc + LAT, 1'b1});
        step(12);
        key_in = 1'b0;
        step(15);
        tests++;
        if (key_state !== 2'd0 || run !== run_m || exp_q.size() != 0) begin
            fails++;
            $display("FAIL mid_after st=%0d run=%0b pending=%0d required st=0 run=%0b pending=0",
                     key_state, run, exp_q.size(), run_m);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 1'b0;
        step(1);
        test_reset();
        test_press("press1");
        test_press("press2");
        test_bounce();
        test_long_press();
        if (run_m) test_press("resync");
        test_reset_mid();
        step(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
